alu_lane_packer: RTL and testbench

- Upstream stage of the integer ALU.
- Accepts one full-warp ALU instruction (NUM_THREADS lanes) from the dispatch side and splits it into NUM_LANES-wide packets for the ALU.
- Each packet carries pid, sop and eop. Packets whose thread-mask slice is all zero are skipped.
- Warp leader thread index (tid) is computed once per instruction and repeated on every packet for branch resolution.

---
 rtl/alu_lane_packer.sv | 137 +++++++++++++
 tb/tb_alu_lane_packer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_lane_packer.sv
// Splits one warp-wide ALU instruction into NUM_LANES-wide packets and skips
// all-zero mask slices. The leader thread index is repeated on every packet.
module alu_lane_packer #(
  parameter  int NUM_THREADS = 4,
  parameter  int NUM_LANES   = 2,
  parameter  int XLEN        = 32,
  parameter  int INFOW       = 64,
  localparam int P           = NUM_THREADS / NUM_LANES,
  localparam int PIDW        = (P > 1) ? $clog2(P) : 1,
  localparam int TIDW        = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INFOW-1:0]            in_info,
  input  logic [NUM_THREADS-1:0]      in_tmask,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs2_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs3_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INFOW-1:0]            out_info,
  output logic [NUM_LANES-1:0]        out_tmask,
  output logic [NUM_LANES*XLEN-1:0]   out_rs1_data,
  output logic [NUM_LANES*XLEN-1:0]   out_rs2_data,
  output logic [NUM_LANES*XLEN-1:0]   out_rs3_data,
  output logic [PIDW-1:0]             out_pid,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [TIDW-1:0]             out_tid
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  typedef struct packed {
    logic [INFOW-1:0]                  info;
    logic [NUM_THREADS-1:0][XLEN-1:0] rs1;
    logic [NUM_THREADS-1:0][XLEN-1:0] rs2;
    logic [NUM_THREADS-1:0][XLEN-1:0] rs3;
  } data_t;

  logic [0:0]             state;
  data_t                  data_r;
  logic [NUM_THREADS-1:0] tmask_r;
  logic [P-1:0]           blk_act_r, blk_in;
  logic [PIDW-1:0]        pid_r, first_blk, nxt_pid;
  logic [TIDW-1:0]        tid_r, tid_in;
  logic                   sop_r, has_nxt, fire, load;

  logic [NUM_LANES-1:0][XLEN-1:0] lane_rs1, lane_rs2, lane_rs3;

  for (genvar b = 0; b < P; b++) begin : g_blk
    assign blk_in[b] = |in_tmask[b*NUM_LANES +: NUM_LANES];
  end

  // Descending scans so the lowest matching index wins.
  always_comb begin
    first_blk = '0;
    for (int i = P-1; i >= 0; i--)
      if (blk_in[i]) first_blk = PIDW'(i);
    tid_in = '0;
    for (int i = NUM_THREADS-1; i >= 0; i--)
      if (in_tmask[i]) tid_in = TIDW'(i);
    has_nxt = 1'b0;
    nxt_pid = pid_r;
    for (int i = P-1; i >= 0; i--)
      if (i > int'(pid_r) && blk_act_r[i]) begin
        has_nxt = 1'b1;
        nxt_pid = PIDW'(i);
      end
  end

  assign out_valid = (state == SEND);
  assign fire      = out_valid & out_ready;
  assign out_eop   = out_valid & ~has_nxt;
  assign in_ready  = (state == IDLE) | (fire & ~has_nxt);
  assign load      = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tmask_r   <= '0;
      blk_act_r <= '0;
      sop_r     <= 1'b0;
      tid_r     <= '0;
    end else if (load) begin
      state     <= SEND;
      tmask_r   <= in_tmask;
      blk_act_r <= blk_in;
      sop_r     <= 1'b1;
      tid_r     <= tid_in;
    end else if (fire) begin
      sop_r <= 1'b0;
      if (!has_nxt) state <= IDLE;
    end
  end

  if (P > 1) begin : g_pid
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)              pid_r <= '0;
      else if (load)           pid_r <= first_blk;
      else if (fire && has_nxt) pid_r <= nxt_pid;
    end
  end else begin : g_pid_tie
    assign pid_r = '0;
  end

  // Payload is qualified by out_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      data_r.info <= in_info;
      data_r.rs1  <= in_rs1_data;
      data_r.rs2  <= in_rs2_data;
      data_r.rs3  <= in_rs3_data;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [TIDW-1:0] idx;
    assign idx          = TIDW'(int'(pid_r) * NUM_LANES + l);
    assign out_tmask[l] = tmask_r[idx];
    assign lane_rs1[l]  = data_r.rs1[idx];
    assign lane_rs2[l]  = data_r.rs2[idx];
    assign lane_rs3[l]  = data_r.rs3[idx];
  end

  assign out_rs1_data = lane_rs1;
  assign out_rs2_data = lane_rs2;
  assign out_rs3_data = lane_rs3;
  assign out_info     = data_r.info;
  assign out_pid      = pid_r;
  assign out_sop      = sop_r;
  assign out_tid      = tid_r;

endmodule

// File: tb/tb_alu_lane_packer.sv
// Bench for alu_lane_packer (4 threads, 2 lanes): directed scenarios plus a
// randomized stream scored against a packet-list reference model.
module tb_alu_lane_packer;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [63:0]  in_info = '0;
  logic [3:0]   in_tmask = '0;
  logic [127:0] in_rs1_data = '0, in_rs2_data = '0, in_rs3_data = '0;
  logic         out_valid, out_ready = 1'b1;
  logic [63:0]  out_info;
  logic [1:0]   out_tmask;
  logic [63:0]  out_rs1_data, out_rs2_data, out_rs3_data;
  logic         out_pid, out_sop, out_eop;
  logic [1:0]   out_tid;

  always #5 clk = ~clk;

  alu_lane_packer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_info(in_info), .in_tmask(in_tmask),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rs3_data(in_rs3_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_info(out_info), .out_tmask(out_tmask),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rs3_data(out_rs3_data),
    .out_pid(out_pid), .out_sop(out_sop), .out_eop(out_eop), .out_tid(out_tid)
  );

  typedef struct {
    logic [63:0] info;
    logic [1:0]  tmask;
    logic [63:0] rs1, rs2, rs3;
    logic        pid, sop, eop;
    logic [1:0]  tid;
  } pkt_t;

  pkt_t exp_q[$];
  pkt_t e;
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Reference: one packet per non-empty 2-thread slice, or a lone pid0 packet.
  function automatic void model(input logic [63:0] info, input logic [3:0] tm,
                                input logic [127:0] r1, input logic [127:0] r2,
                                input logic [127:0] r3);
    int act[$];
    logic [1:0] tid = 2'd0;
    pkt_t p;
    for (int t = 3; t >= 0; t--) if (tm[t]) tid = 2'(t);
    for (int b = 0; b < 2; b++) if (tm[2*b +: 2] != 2'b00) act.push_back(b);
    if (act.size() == 0) act.push_back(0);
    foreach (act[k]) begin
      p.info  = info;
      p.pid   = 1'(act[k]);
      p.tmask = tm[2*act[k] +: 2];
      p.rs1   = r1[64*act[k] +: 64];
      p.rs2   = r2[64*act[k] +: 64];
      p.rs3   = r3[64*act[k] +: 64];
      p.sop   = (k == 0);
      p.eop   = (k == act.size() - 1);
      p.tid   = tid;
      exp_q.push_back(p);
    end
  endfunction

  function automatic logic [63:0] ctl();
    return 64'({out_valid, out_sop, out_eop, out_pid, out_tid, out_tmask});
  endfunction

  // Stream monitor: scores every fire, checks stability across stalls, feeds model on accept.
  logic [63:0] h_ctl, h_info, h_rs1, h_rs2, h_rs3;
  bit held = 1'b0;
  always @(negedge clk) begin
    if (!reset) held = 1'b0;
    else begin
      if (held) begin
        chk("hold_ctl", ctl(), h_ctl);
        chk("hold_info", out_info, h_info);
        chk("hold_rs1", out_rs1_data, h_rs1);
        chk("hold_rs2", out_rs2_data, h_rs2);
        chk("hold_rs3", out_rs3_data, h_rs3);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_pkt", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("pkt_pid", out_pid, e.pid);
          chk("pkt_sop", out_sop, e.sop);
          chk("pkt_eop", out_eop, e.eop);
          chk("pkt_tid", out_tid, e.tid);
          chk("pkt_tmask", out_tmask, e.tmask);
          chk("pkt_info", out_info, e.info);
          chk("pkt_rs1", out_rs1_data, e.rs1);
          chk("pkt_rs2", out_rs2_data, e.rs2);
          chk("pkt_rs3", out_rs3_data, e.rs3);
        end
      end
      held  = out_valid && !out_ready;
      h_ctl = ctl(); h_info = out_info;
      h_rs1 = out_rs1_data; h_rs2 = out_rs2_data; h_rs3 = out_rs3_data;
      if (in_valid && in_ready) model(in_info, in_tmask, in_rs1_data, in_rs2_data, in_rs3_data);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_instr(input logic [3:0] tm, input logic [127:0] r1);
    in_info     = {$urandom, $urandom};
    in_tmask    = tm;
    in_rs1_data = r1;
    in_rs2_data = {$urandom, $urandom, $urandom, $urandom};
    in_rs3_data = {$urandom, $urandom, $urandom, $urandom};
    in_valid    = 1'b1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic pid, input logic sop,
                            input logic eop, input logic [1:0] tm, input logic [1:0] tid);
    chk({tag, "_valid"}, out_valid, v);
    if (v) begin
      chk({tag, "_pid"}, out_pid, pid);
      chk({tag, "_sop"}, out_sop, sop);
      chk({tag, "_eop"}, out_eop, eop);
      chk({tag, "_tmask"}, out_tmask, tm);
      chk({tag, "_tid"}, out_tid, tid);
    end
  endtask

  logic [127:0] lanes1234;
  bit acc;
  int sent, cyc;

  initial begin
    lanes1234 = {32'd4, 32'd3, 32'd2, 32'd1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sop", out_sop, 1'b0);
    chk("rst_eop", out_eop, 1'b0);
    chk("rst_pid", out_pid, 1'b0);
    chk("rst_tid", out_tid, 2'd0);
    chk("rst_tmask", out_tmask, 2'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    step(); reset = 1'b1;

    // Full mask: two packets, one cycle after accept
    step(); set_instr(4'b1111, lanes1234);
    @(negedge clk); chk("s1_in_ready", in_ready, 1'b1); chk("s1_latency", out_valid, 1'b0);
    step(); in_valid = 1'b0;
    @(negedge clk); expect_out("s1_p0", 1, 0, 1, 0, 2'b11, 0);
    chk("s1_p0_rs1", out_rs1_data, 64'h00000002_00000001); chk("s1_p0_rdy", in_ready, 1'b0);
    step(); @(negedge clk); expect_out("s1_p1", 1, 1, 0, 1, 2'b11, 0);
    chk("s1_p1_rs1", out_rs1_data, 64'h00000004_00000003); chk("s1_p1_rdy", in_ready, 1'b1);
    step(); @(negedge clk); chk("s1_idle", out_valid, 1'b0);

    // Upper slice only
    step(); set_instr(4'b1100, lanes1234);
    @(negedge clk); step(); in_valid = 1'b0;
    @(negedge clk); expect_out("s2", 1, 1, 1, 1, 2'b11, 2);
    step(); @(negedge clk); chk("s2_idle", out_valid, 1'b0);

    // Empty mask still yields one packet
    step(); set_instr(4'b0000, lanes1234);
    @(negedge clk); step(); in_valid = 1'b0;
    @(negedge clk); expect_out("s3", 1, 0, 1, 1, 2'b00, 0);
    step(); @(negedge clk); chk("s3_idle", out_valid, 1'b0);

    // Back-to-back, no bubble
    step(); set_instr(4'b1111, lanes1234);
    @(negedge clk); step(); set_instr(4'b0011, lanes1234);
    @(negedge clk); expect_out("s4_a", 1, 0, 1, 0, 2'b11, 0); chk("s4_a_rdy", in_ready, 1'b0);
    step(); @(negedge clk); expect_out("s4_b", 1, 1, 0, 1, 2'b11, 0); chk("s4_b_rdy", in_ready, 1'b1);
    step(); in_valid = 1'b0;
    @(negedge clk); expect_out("s4_c", 1, 0, 1, 1, 2'b11, 0);
    step(); @(negedge clk); chk("s4_idle", out_valid, 1'b0);

    // Stall three cycles on the first packet
    step(); out_ready = 1'b0; set_instr(4'b1111, lanes1234);
    @(negedge clk); step(); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); expect_out("s5_stall", 1, 0, 1, 0, 2'b11, 0); chk("s5_stall_rdy", in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk); expect_out("s5_a", 1, 0, 1, 0, 2'b11, 0);
    step(); @(negedge clk); expect_out("s5_b", 1, 1, 0, 1, 2'b11, 0);
    step(); @(negedge clk); chk("s5_idle", out_valid, 1'b0); chk("s5_queue", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-instruction
    step(); set_instr(4'b1111, lanes1234);
    @(negedge clk); step(); in_valid = 1'b0;
    @(negedge clk); expect_out("s6_p0", 1, 0, 1, 0, 2'b11, 0);
    step(); #1 reset = 1'b0; #1;
    chk("s6_async_valid", out_valid, 1'b0);
    chk("s6_async_eop", out_eop, 1'b0);
    chk("s6_async_pid", out_pid, 1'b0);
    chk("s6_async_tmask", out_tmask, 2'd0);
    exp_q.delete();
    step(); step(); reset = 1'b1;
    @(negedge clk); chk("s6_post_idle", out_valid, 1'b0);
    step(); set_instr(4'b1100, lanes1234);
    @(negedge clk); step(); in_valid = 1'b0;
    @(negedge clk); expect_out("s6_new", 1, 1, 1, 1, 2'b11, 2);
    step(); @(negedge clk); chk("s6_idle", out_valid, 1'b0);

    // Randomized stream with random backpressure
    acc = 1'b0; sent = 0; cyc = 0;
    while (sent < 150 && cyc < 5000) begin
      step(); cyc++;
      if (acc) begin in_valid = 1'b0; acc = 1'b0; end
      if (!in_valid && $urandom_range(0, 3) != 0)
        set_instr(4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom});
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin acc = 1'b1; sent++; end
    end
    chk("rand_sent", 64'(sent), 64'd150);
    step(); in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("rand_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
